// File: rtl/time_pkg.sv
// Shared types and constants for the seconds/minutes time base.
// Both BCD counters and the control FSM import this package.
package time_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int unsigned SEC_MAX_T = 5;
  localparam int unsigned SEC_MAX_O = 9;
  localparam int unsigned MIN_MAX_T = 5;
  localparam int unsigned MIN_MAX_O = 9;

endpackage

// File: rtl/time_base_ctrl_if.sv
// Button inputs and display/hour-counter outputs of the time base.
// The slave modport is the controller's view; master is the driver's view.
interface time_base_ctrl_if;

  logic               MODE;
  logic               UP;
  logic               HINC;
  logic               HCLR;
  logic [2:0]         MH;
  time_pkg::bcd_t     ML;
  logic [2:0]         SH;
  time_pkg::bcd_t     SL;
  time_pkg::state_t   STATE;
  logic               BLINK;

  modport slave (
    input  MODE, UP,
    output HINC, HCLR, MH, ML, SH, SL, STATE, BLINK
  );

  modport master (
    output MODE, UP,
    input  HINC, HCLR, MH, ML, SH, SL, STATE, BLINK
  );

endinterface

// File: rtl/bcd60_cnt.sv
// Two-digit BCD counter 00..(MAX_T)(MAX_O) with clear, increment and
// a combinational carry on the increment that wraps the count.
module bcd60_cnt
  import time_pkg::*;
#(
  parameter int unsigned MAX_T = SEC_MAX_T,
  parameter int unsigned MAX_O = SEC_MAX_O
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       INC,
  output logic [2:0] tens,
  output bcd_t       ones,
  output logic       CY
);

  localparam logic [2:0] TENS_LAST = 3'(MAX_T);
  localparam bcd_t       ONES_LAST = 4'(MAX_O);

  logic [2:0] tens_q, tens_d;
  bcd_t       ones_q, ones_d;
  logic       at_last;

  assign at_last = (tens_q == TENS_LAST) && (ones_q == ONES_LAST);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (CLR) begin
      tens_d = '0;
      ones_d = '0;
    end else if (INC) begin
      if (ones_q == ONES_LAST) begin
        ones_d = '0;
        tens_d = (tens_q == TENS_LAST) ? 3'd0 : tens_q + 3'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;
  assign CY   = INC && at_last;

  // Digits beyond the limits can only appear through a logic fault.
  a_digits_legal: assert property (@(posedge CLK) disable iff (RST)
    (tens_q <= TENS_LAST) && (ones_q <= ONES_LAST));

endmodule

// File: rtl/time_base_ctrl.sv
// Seconds/minutes time base with MODE/UP time-setting; drives the
// hour counter's increment (HINC) and clear (HCLR).
module time_base_ctrl
  import time_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic                   CLK,
  input  logic                   RST,
  time_base_ctrl_if.slave        bus
);

  localparam int unsigned   PW       = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2);

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          hinc_q, hinc_d;
  logic          blink_q, blink_d;
  logic          hclr_q;
  logic          tick;
  logic          sec_clr, sec_inc, sec_cy;
  logic          min_inc, min_cy;
  logic [2:0]    sec_t, min_t;
  bcd_t          sec_o, min_o;

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.MODE) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        default:  state_d = RUN;
      endcase
    end
  end

  // MODE wins over UP and over the second tick in every state.
  always_comb begin
    sec_clr = bus.MODE;
    sec_inc = tick && (state_q == RUN) && !bus.MODE;
    min_inc = 1'b0;
    hinc_d  = 1'b0;
    pre_d   = (bus.MODE || tick) ? '0 : pre_q + 1'b1;
    case (state_q)
      RUN: begin
        min_inc = sec_cy;
        hinc_d  = min_cy;
      end
      SET_HOUR: hinc_d  = bus.UP && !bus.MODE;
      SET_MIN:  min_inc = bus.UP && !bus.MODE;
      default: ;
    endcase
    blink_d = (state_d != RUN) && (pre_d < PRE_HALF);
  end

  always_ff @(posedge CLK) begin
    hclr_q <= RST;
    if (RST) begin
      pre_q   <= '0;
      hinc_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      hinc_q  <= hinc_d;
      blink_q <= blink_d;
    end
  end

  bcd60_cnt #(.MAX_T(SEC_MAX_T), .MAX_O(SEC_MAX_O)) u_sec (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (sec_clr),
    .INC  (sec_inc),
    .tens (sec_t),
    .ones (sec_o),
    .CY   (sec_cy)
  );

  bcd60_cnt #(.MAX_T(MIN_MAX_T), .MAX_O(MIN_MAX_O)) u_min (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (1'b0),
    .INC  (min_inc),
    .tens (min_t),
    .ones (min_o),
    .CY   (min_cy)
  );

  assign bus.HINC  = hinc_q;
  assign bus.HCLR  = hclr_q;
  assign bus.MH    = min_t;
  assign bus.ML    = min_o;
  assign bus.SH    = sec_t;
  assign bus.SL    = sec_o;
  assign bus.STATE = state_q;
  assign bus.BLINK = blink_q;

endmodule

// File: tb/tb_time_base_ctrl.sv
// Directed self-checking bench for time_base_ctrl with CLK_HZ = 4.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_time_base_ctrl;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   hinc_cnt;
  int   hinc_dbl;
  int   blink_seen;
  logic hinc_prev;

  time_base_ctrl_if bus ();

  time_base_ctrl #(.CLK_HZ(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.HINC === 1'b1) hinc_cnt++;
      if (bus.HINC === 1'b1 && hinc_prev === 1'b1) hinc_dbl++;
      if (bus.BLINK === 1'b1) blink_seen++;
      hinc_prev = bus.HINC;
    end
  endtask

  task automatic pulse_mode();
    bus.MODE = 1'b1;
    step(1);
    bus.MODE = 1'b0;
  endtask

  task automatic pulse_up(input int n);
    for (int i = 0; i < n; i++) begin
      bus.UP = 1'b1;
      step(1);
      bus.UP = 1'b0;
      step(1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    tests_run++;
    if (bus.HCLR !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_hclr: got %b expected 1", bus.HCLR); end
    tests_run++;
    if ({bus.MH, bus.ML, bus.SH, bus.SL} !== 14'd0) begin tests_failed++; $display("[TB] FAIL reset_digits: got %0d%0d:%0d%0d expected 00:00", bus.MH, bus.ML, bus.SH, bus.SL); end
    tests_run++;
    if (bus.STATE !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d expected 0", bus.STATE); end
    tests_run++;
    if (bus.HINC !== 1'b0 || bus.BLINK !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hinc_blink: got %b%b expected 00", bus.HINC, bus.BLINK); end
    rst = 1'b0;
    step(1);
    tests_run++;
    if (bus.HCLR !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hclr_release: got %b expected 0", bus.HCLR); end
  endtask

  // One edge since reset release has already elapsed on entry.
  task automatic test_run_count();
    hinc_cnt = 0;
    blink_seen = 0;
    step(2);
    tests_run++;
    if (bus.SL !== 4'd0) begin tests_failed++; $display("[TB] FAIL run_before_tick: got %0d expected 0", bus.SL); end
    step(1);
    tests_run++;
    if (bus.SL !== 4'd1) begin tests_failed++; $display("[TB] FAIL run_first_tick: got %0d expected 1", bus.SL); end
    step(236);
    tests_run++;
    if ({bus.MH, bus.ML, bus.SH, bus.SL} !== {3'd0, 4'd1, 3'd0, 4'd0}) begin tests_failed++; $display("[TB] FAIL run_240: got %0d%0d:%0d%0d expected 01:00", bus.MH, bus.ML, bus.SH, bus.SL); end
    tests_run++;
    if (hinc_cnt !== 0 || blink_seen !== 0) begin tests_failed++; $display("[TB] FAIL run_no_hinc_blink: got hinc=%0d blink=%0d expected 0 0", hinc_cnt, blink_seen); end
  endtask

  task automatic test_set_hour();
    pulse_mode();
    tests_run++;
    if (bus.STATE !== 2'd1 || bus.BLINK !== 1'b1) begin tests_failed++; $display("[TB] FAIL set_hour_enter: got state=%0d blink=%b expected 1 1", bus.STATE, bus.BLINK); end
    hinc_cnt = 0;
    hinc_dbl = 0;
    for (int k = 0; k < 3; k++) begin
      bus.UP = 1'b1;
      step(1);
      bus.UP = 1'b0;
      tests_run++;
      if (bus.HINC !== 1'b1) begin tests_failed++; $display("[TB] FAIL set_hour_pulse%0d: got %b expected 1", k, bus.HINC); end
      step(1);
      tests_run++;
      if (bus.HINC !== 1'b0) begin tests_failed++; $display("[TB] FAIL set_hour_gap%0d: got %b expected 0", k, bus.HINC); end
    end
    tests_run++;
    if (hinc_cnt !== 3 || hinc_dbl !== 0) begin tests_failed++; $display("[TB] FAIL set_hour_count: got %0d pulses %0d doubles expected 3 0", hinc_cnt, hinc_dbl); end
    tests_run++;
    if (bus.ML !== 4'd1 || bus.SL !== 4'd0 || bus.STATE !== 2'd1) begin tests_failed++; $display("[TB] FAIL set_hour_hold: got ML=%0d SL=%0d state=%0d expected 1 0 1", bus.ML, bus.SL, bus.STATE); end
    // Prescaler is now 2, the first value of the dark half.
    tests_run++;
    if (bus.BLINK !== 1'b0) begin tests_failed++; $display("[TB] FAIL set_hour_blink_off: got %b expected 0", bus.BLINK); end
  endtask

  task automatic test_mode_up_conflict();
    hinc_cnt = 0;
    bus.MODE = 1'b1;
    bus.UP = 1'b1;
    step(1);
    bus.MODE = 1'b0;
    bus.UP = 1'b0;
    step(1);
    tests_run++;
    if (bus.STATE !== 2'd2 || hinc_cnt !== 0) begin tests_failed++; $display("[TB] FAIL mode_up_conflict: got state=%0d hinc=%0d expected 2 0", bus.STATE, hinc_cnt); end
  endtask

  task automatic test_set_min_wrap();
    do_reset();
    pulse_mode();
    pulse_mode();
    hinc_cnt = 0;
    pulse_up(59);
    tests_run++;
    if (bus.MH !== 3'd5 || bus.ML !== 4'd9) begin tests_failed++; $display("[TB] FAIL set_min_59: got %0d%0d expected 59", bus.MH, bus.ML); end
    pulse_up(1);
    tests_run++;
    if (bus.MH !== 3'd0 || bus.ML !== 4'd0) begin tests_failed++; $display("[TB] FAIL set_min_wrap: got %0d%0d expected 00", bus.MH, bus.ML); end
    pulse_up(1);
    tests_run++;
    if (bus.MH !== 3'd0 || bus.ML !== 4'd1 || hinc_cnt !== 0) begin tests_failed++; $display("[TB] FAIL set_min_61: got %0d%0d hinc=%0d expected 01 0", bus.MH, bus.ML, hinc_cnt); end
    pulse_mode();
    tests_run++;
    if (bus.STATE !== 2'd0 || bus.SH !== 3'd0 || bus.SL !== 4'd0) begin tests_failed++; $display("[TB] FAIL set_min_exit: got state=%0d sec=%0d%0d expected 0 00", bus.STATE, bus.SH, bus.SL); end
    step(3);
    tests_run++;
    if (bus.SL !== 4'd0) begin tests_failed++; $display("[TB] FAIL exit_before_tick: got %0d expected 0", bus.SL); end
    step(1);
    tests_run++;
    if (bus.SL !== 4'd1) begin tests_failed++; $display("[TB] FAIL exit_first_tick: got %0d expected 1", bus.SL); end
  endtask

  task automatic test_carry();
    do_reset();
    pulse_mode();
    pulse_mode();
    pulse_up(59);
    pulse_mode();
    tests_run++;
    if (bus.STATE !== 2'd0 || bus.MH !== 3'd5 || bus.ML !== 4'd9) begin tests_failed++; $display("[TB] FAIL carry_setup: got state=%0d min=%0d%0d expected 0 59", bus.STATE, bus.MH, bus.ML); end
    hinc_cnt = 0;
    hinc_dbl = 0;
    step(239);
    tests_run++;
    if ({bus.MH, bus.ML, bus.SH, bus.SL} !== {3'd5, 4'd9, 3'd5, 4'd9} || hinc_cnt !== 0) begin tests_failed++; $display("[TB] FAIL carry_pre: got %0d%0d:%0d%0d hinc=%0d expected 59:59 0", bus.MH, bus.ML, bus.SH, bus.SL, hinc_cnt); end
    step(1);
    tests_run++;
    if ({bus.MH, bus.ML, bus.SH, bus.SL} !== 14'd0 || bus.HINC !== 1'b1) begin tests_failed++; $display("[TB] FAIL carry_wrap: got %0d%0d:%0d%0d hinc=%b expected 00:00 1", bus.MH, bus.ML, bus.SH, bus.SL, bus.HINC); end
    step(1);
    tests_run++;
    if (bus.HINC !== 1'b0 || hinc_cnt !== 1 || hinc_dbl !== 0) begin tests_failed++; $display("[TB] FAIL carry_single: got hinc=%b count=%0d expected 0 1", bus.HINC, hinc_cnt); end
  endtask

  // Prescaler is 1 on entry; two more edges bring it to the tick value.
  task automatic test_mode_tick_conflict();
    step(2);
    pulse_mode();
    tests_run++;
    if (bus.STATE !== 2'd1 || bus.SL !== 4'd0) begin tests_failed++; $display("[TB] FAIL mode_tick_conflict: got state=%0d SL=%0d expected 1 0", bus.STATE, bus.SL); end
  endtask

  task automatic test_reset_mid();
    pulse_mode();
    pulse_up(7);
    tests_run++;
    if (bus.STATE !== 2'd2 || bus.ML !== 4'd7) begin tests_failed++; $display("[TB] FAIL reset_mid_setup: got state=%0d ML=%0d expected 2 7", bus.STATE, bus.ML); end
    rst = 1'b1;
    step(1);
    tests_run++;
    if (bus.STATE !== 2'd0 || {bus.MH, bus.ML, bus.SH, bus.SL} !== 14'd0 || bus.HCLR !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_mid: got state=%0d min=%0d%0d hclr=%b expected 0 00 1", bus.STATE, bus.MH, bus.ML, bus.HCLR); end
    step(1);
    tests_run++;
    if (bus.HCLR !== 1'b1 || bus.BLINK !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_held: got hclr=%b blink=%b expected 1 0", bus.HCLR, bus.BLINK); end
    rst = 1'b0;
    step(1);
    tests_run++;
    if (bus.HCLR !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mid_release: got %b expected 0", bus.HCLR); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    hinc_cnt = 0;
    hinc_dbl = 0;
    blink_seen = 0;
    hinc_prev = 1'b0;
    rst = 1'b1;
    bus.MODE = 1'b0;
    bus.UP = 1'b0;
    test_reset();
    test_run_count();
    test_set_hour();
    test_mode_up_conflict();
    test_set_min_wrap();
    test_carry();
    test_mode_tick_conflict();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
